// File: rtl/fsm1101_pkg.sv
// fsm1101_pkg: definitions shared by the 1101 frame transmitter and the
// 1101 sequence detectors.
//   state_t   - transmitter FSM state encoding
//   PREAMBLE  - frame sync word, sent MSB first (the detectors look for it)
//   STUFF_PAT - three most recent line bits that force a stuffed 0
//   HIST_INIT - last three preamble bits, the history seen when payload starts
package fsm1101_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_PRE   = 3'd1,
    ST_DATA  = 3'd2,
    ST_STUFF = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  localparam logic [3:0] PREAMBLE  = 4'b1101;
  localparam logic [2:0] STUFF_PAT = 3'b110;
  localparam logic [2:0] HIST_INIT = 3'b101;

endpackage

// File: rtl/tx_1101.sv
// tx_1101: serial frame transmitter. Each accepted WIDTH-bit word goes out
// MSB first behind a 1101 preamble. A 0 is stuffed whenever the last three
// line bits are 110 and payload remains, so 1101 never reappears inside the
// frame.
// Ports:
//   clk   - clock, all state changes on posedge
//   reset - synchronous active-high reset, highest priority
//   start - frame request, honoured only in IDLE
//   data  - payload, captured on the accepting edge
//   x     - registered serial line
//   busy  - registered, high while preamble/payload/stuff bits are on x
//   done  - registered one-cycle pulse after the last payload bit
//   stuff - registered, high while x carries a stuffed 0
module tx_1101
  import fsm1101_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] data,
  output logic             x,
  output logic             busy,
  output logic             done,
  output logic             stuff
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH);

  state_t           state_r, state_n;
  logic [1:0]       pre_idx_r, pre_idx_n;
  logic [CW-1:0]    cnt_r, cnt_n;
  logic [WIDTH-1:0] shreg_r, shreg_n;
  logic [2:0]       hist_r, hist_n;
  logic             x_n;
  logic             x_fix_s;
  logic             load_bit_s;
  logic             capture_s;

  // Next-state logic. The registered outputs reflect the state being
  // entered, so every output change lands on the same edge as the state.
  // cnt_r counts payload bits already placed on x; hist_r holds the last
  // three bits placed on x, including the one currently driven.
  always_comb begin
    state_n    = state_r;
    pre_idx_n  = pre_idx_r;
    hist_n     = hist_r;
    x_fix_s    = 1'b0;
    load_bit_s = 1'b0;
    capture_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          state_n   = ST_PRE;
          capture_s = 1'b1;
          pre_idx_n = 2'd0;
          x_fix_s   = PREAMBLE[3];
        end else begin
          state_n = ST_IDLE;
        end
      end
      ST_PRE: begin
        if (pre_idx_r == 2'd3) begin
          // The first payload bit joins the preamble tail in the history.
          state_n    = ST_DATA;
          load_bit_s = 1'b1;
          hist_n     = {HIST_INIT[1:0], shreg_r[WIDTH-1]};
        end else begin
          pre_idx_n = pre_idx_r + 2'd1;
          x_fix_s   = PREAMBLE[2'd2 - pre_idx_r];
        end
      end
      ST_DATA: begin
        if (cnt_r == LAST_CNT) begin
          state_n = ST_DONE;
        end else if (hist_r == STUFF_PAT) begin
          state_n = ST_STUFF;
          hist_n  = {hist_r[1:0], 1'b0};
        end else begin
          load_bit_s = 1'b1;
          hist_n     = {hist_r[1:0], shreg_r[WIDTH-1]};
        end
      end
      ST_STUFF: begin
        state_n    = ST_DATA;
        load_bit_s = 1'b1;
        hist_n     = {hist_r[1:0], shreg_r[WIDTH-1]};
      end
      ST_DONE: begin
        state_n = ST_IDLE;
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase

    // Payload shifter: shreg_r[WIDTH-1] is always the next bit to send.
    if (capture_s) begin
      shreg_n = data;
      cnt_n   = '0;
      x_n     = x_fix_s;
    end else if (load_bit_s) begin
      shreg_n = shreg_r << 1;
      cnt_n   = cnt_r + CW'(1);
      x_n     = shreg_r[WIDTH-1];
    end else begin
      shreg_n = shreg_r;
      cnt_n   = cnt_r;
      x_n     = x_fix_s;
    end
  end

  // State, datapath and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= ST_IDLE;
      pre_idx_r <= 2'd0;
      cnt_r     <= '0;
      shreg_r   <= '0;
      hist_r    <= 3'b000;
      x         <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      stuff     <= 1'b0;
    end else begin
      state_r   <= state_n;
      pre_idx_r <= pre_idx_n;
      cnt_r     <= cnt_n;
      shreg_r   <= shreg_n;
      hist_r    <= hist_n;
      x         <= x_n;
      busy      <= (state_n == ST_PRE) || (state_n == ST_DATA) || (state_n == ST_STUFF);
      done      <= (state_n == ST_DONE);
      stuff     <= (state_n == ST_STUFF);
    end
  end

endmodule

// File: tb/tb_tx_1101.sv
// tb_tx_1101: scoreboard bench for tx_1101. The driver pushes the expected
// line contents of each frame (built directly from the framing rules) into a
// queue; a monitor pops one entry per busy/done cycle and compares.
module tb_tx_1101;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [W-1:0] data;
  logic         x, busy, done, stuff;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic x;
    logic stuff;
    logic done;
  } exp_t;

  exp_t exp_q[$];
  int   det_cnt = 0;

  tx_1101 #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .data  (data),
    .x     (x),
    .busy  (busy),
    .done  (done),
    .stuff (stuff)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int got, input int want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, want, $time);
    end
  endtask

  function automatic void push_exp(input logic xv, input logic sv, input logic dv);
    exp_t e;
    e.x = xv;
    e.stuff = sv;
    e.done = dv;
    exp_q.push_back(e);
  endfunction

  // Reference framing: preamble, payload MSB first, a 0 after any payload
  // bit (other than the last) that leaves 1,1,0 as the latest line bits.
  // Returns the number of busy cycles in the frame.
  function automatic int build(input logic [W-1:0] d);
    logic line[$];
    int   n;
    line = '{1'b1, 1'b1, 1'b0, 1'b1};
    foreach (line[k]) push_exp(line[k], 1'b0, 1'b0);
    n = 4;
    for (int i = W - 1; i >= 0; i--) begin
      push_exp(d[i], 1'b0, 1'b0);
      line.push_back(d[i]);
      n++;
      if (i > 0 && line[line.size()-3] == 1'b1 && line[line.size()-2] == 1'b1
          && line[line.size()-1] == 1'b0) begin
        push_exp(1'b0, 1'b1, 1'b0);
        line.push_back(1'b0);
        n++;
      end
    end
    push_exp(1'b0, 1'b0, 1'b1);
    return n;
  endfunction

  // Monitor: compare every busy/done cycle against the queue, keep the line
  // idle-low otherwise, and count 1101 occurrences per frame.
  initial begin : monitor
    logic [3:0] win;
    exp_t e;
    win = 4'b0000;
    forever begin
      @(negedge clk);
      if (reset) begin
        det_cnt = 0;
        win = 4'b0000;
      end
      win = {win[2:0], x};
      if (win == 4'b1101) det_cnt++;
      if (busy || done) begin
        if (exp_q.size() == 0) begin
          check("unexpected_output", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("x", x, e.x);
          check("stuff", stuff, e.stuff);
          check("done", done, e.done);
          check("busy", busy, !e.done);
          if (e.done) begin
            check("detect_once", det_cnt, 1);
            det_cnt = 0;
          end
        end
      end else begin
        check("idle_x", x, 0);
        check("idle_stuff", stuff, 0);
      end
    end
  end

  // Waits (bounded) for done; returns the cycle index relative to the
  // latency-check negedge, which is cycle 1.
  task automatic wait_done(output int cyc);
    bit seen = 0;
    cyc = 1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      cyc++;
      if (done) begin
        seen = 1;
        break;
      end
    end
    check("done_seen", seen, 1);
  endtask

  // Called at a negedge with the DUT in IDLE; returns at the next IDLE negedge.
  task automatic send(input logic [W-1:0] d, input bit toggle);
    int n, cyc;
    n = build(d);
    start = 1'b1;
    data  = d;
    @(posedge clk);
    #1;
    start = 1'b0;
    data  = W'($urandom);
    @(negedge clk);
    check("first_x_latency", x, 1);
    check("busy_latency", busy, 1);
    if (toggle) begin
      for (int i = 0; i < 8; i++) begin
        start = 1'($urandom);
        data  = W'($urandom);
        @(negedge clk);
      end
      start = 1'b0;
    end
    wait_done(cyc);
    if (!toggle) check("done_cycle", cyc, n + 1);
    @(negedge clk);
  endtask

  initial begin : driver
    int n, cyc;
    reset = 1'b1;
    start = 1'b0;
    data  = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_x", x, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_stuff", stuff, 0);
    reset = 1'b0;
    @(negedge clk);

    // Directed frames: no stuffing, two stuffs, trailing 110, busy toggling.
    send(8'hFF, 1'b0);
    send(8'hDD, 1'b0);
    send(8'h06, 1'b0);
    send(8'hA5, 1'b1);

    // Reset in the middle of an 8'hFF frame.
    n = build(8'hFF);
    start = 1'b1;
    data  = 8'hFF;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    exp_q.delete();
    check("abort_x", x, 0);
    check("abort_busy", busy, 0);
    repeat (14) @(negedge clk);
    send(8'hFF, 1'b0);

    // Back-to-back with start held high: one IDLE cycle after DONE.
    n = build(8'h0F);
    n = build(8'hDD);
    start = 1'b1;
    data  = 8'h0F;
    @(posedge clk);
    #1;
    data = 8'hDD;
    wait_done(cyc);
    @(negedge clk);
    check("b2b_gap_busy", busy, 0);
    check("b2b_gap_x", x, 0);
    @(negedge clk);
    check("b2b_restart_busy", busy, 1);
    check("b2b_restart_x", x, 1);
    start = 1'b0;
    wait_done(cyc);
    @(negedge clk);

    // Random payloads.
    for (int i = 0; i < 30; i++) begin
      send(W'($urandom), 1'($urandom));
    end

    repeat (3) @(negedge clk);
    check("queue_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
